// File: rtl/issue_queue.sv
// Purpose : age-ordered, compacting issue queue with a 64-entry phyReg ready
//           scoreboard, wakeup broadcast and oldest-ready-first selection.
// Ports   : CLK/RESET (async active-low); FREEZE stall; entry_IN + do_write_ISSQUEUE
//           write; mispredict/flush_fCOM flush; wakeup_valid_IN/wakeup_phyReg_IN
//           broadcast; exec_ready_IN; issue_entry_OUT/issue_valid_OUT (registered);
//           full_ISSQUEUE, empty_ISSQUEUE, overflow_OUT, count_OUT.
// Latency : a write at edge E is selectable in cycle E+1 and appears on issue_entry_OUT
//           after edge E+1 at the earliest. A write to a full queue is dropped unless
//           an issue frees a slot on the same edge; a dropped write sets overflow_OUT.
// Option  : define ISSQ_WAKEUP_BYPASS_EN to let a wakeup count as ready for
//           selection in the same cycle it is broadcast.
module issue_queue #(
    parameter int DEPTH            = 8,
    parameter int ISSUE_ENTRY_SIZE = 192
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        FREEZE,
    input  logic [ISSUE_ENTRY_SIZE-1:0] entry_IN,
    input  logic                        do_write_ISSQUEUE,
    input  logic                        mispredict,
    input  logic                        flush_fCOM,
    input  logic                        wakeup_valid_IN,
    input  logic [5:0]                  wakeup_phyReg_IN,
    input  logic                        exec_ready_IN,
    output logic [ISSUE_ENTRY_SIZE-1:0] issue_entry_OUT,
    output logic                        issue_valid_OUT,
    output logic                        full_ISSQUEUE,
    output logic                        empty_ISSQUEUE,
    output logic                        overflow_OUT,
    output logic [$clog2(DEPTH):0]      count_OUT
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ISSUE_ENTRY_SIZE-1:0] slots_q [DEPTH];
    logic [CW-1:0]               count_q;
    logic [63:0]                 sb_q;

    logic [ISSUE_ENTRY_SIZE-1:0] upd      [DEPTH];
    logic [ISSUE_ENTRY_SIZE-1:0] nxt      [DEPTH];
    logic [ISSUE_ENTRY_SIZE-1:0] new_entry;
    logic [ISSUE_ENTRY_SIZE-1:0] iss_entry;
    logic [DEPTH-1:0]            occ;
    logic [DEPTH-1:0]            rdy;
    logic [CW-1:0]               sel;
    logic [CW-1:0]               tail;
    logic [CW-1:0]               count_nxt;
    logic [63:0]                 sb_nxt;
    logic                        flush;
    logic                        found;
    logic                        issue;
    logic                        wr_try;
    logic                        wr_acc;

    always_comb begin
        flush     = mispredict | flush_fCOM;
        found     = 1'b0;
        sel       = '0;
        iss_entry = '0;
        occ       = '0;
        rdy       = '0;

        // Apply this cycle's wakeup to every occupied slot.
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = CW'(i) < count_q;
            upd[i] = slots_q[i];
            if (occ[i] && wakeup_valid_IN && slots_q[i][166:161] == wakeup_phyReg_IN)
                upd[i][160] = 1'b1;
            if (occ[i] && wakeup_valid_IN && slots_q[i][173:168] == wakeup_phyReg_IN)
                upd[i][167] = 1'b1;
`ifdef ISSQ_WAKEUP_BYPASS_EN
            rdy[i] = occ[i] & upd[i][160] & upd[i][167];
`else
            rdy[i] = occ[i] & slots_q[i][160] & slots_q[i][167];
`endif
        end

        // Oldest ready entry wins; slot 0 is the oldest.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                found = 1'b1;
                sel   = CW'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) == sel)
                iss_entry = upd[i];
        end
        iss_entry[180] = 1'b1;

        issue  = found & exec_ready_IN & ~FREEZE & ~flush;
        wr_try = do_write_ISSQUEUE & ~FREEZE & ~flush;
        wr_acc = wr_try & ((count_q != CW'(DEPTH)) | issue);

        // Incoming operands may already be ready through the scoreboard or a
        // wakeup landing on the same edge.
        new_entry = entry_IN;
        if (sb_q[entry_IN[166:161]] || (wakeup_valid_IN && wakeup_phyReg_IN == entry_IN[166:161]))
            new_entry[160] = 1'b1;
        if (sb_q[entry_IN[173:168]] || (wakeup_valid_IN && wakeup_phyReg_IN == entry_IN[173:168]))
            new_entry[167] = 1'b1;

        // Compaction: everything above the issued slot moves down one.
        for (int i = 0; i < DEPTH - 1; i++) begin
            nxt[i] = (issue && CW'(i) >= sel) ? upd[i+1] : upd[i];
        end
        nxt[DEPTH-1] = issue ? '0 : upd[DEPTH-1];

        tail = count_q - CW'(issue);
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_acc && tail == CW'(i))
                nxt[i] = new_entry;
        end
        count_nxt = tail + CW'(wr_acc);

        // Newly allocated dest is not ready even if its old producer wakes now.
        sb_nxt = sb_q;
        if (wakeup_valid_IN)
            sb_nxt[wakeup_phyReg_IN] = 1'b1;
        if (wr_acc)
            sb_nxt[entry_IN[179:174]] = 1'b0;
        sb_nxt[0] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++)
                slots_q[i] <= '0;
            count_q         <= '0;
            sb_q            <= 64'h1;
            overflow_OUT    <= 1'b0;
            issue_entry_OUT <= '0;
            issue_valid_OUT <= 1'b0;
        end else begin
            sb_q <= sb_nxt;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++)
                    slots_q[i] <= '0;
                count_q         <= '0;
                overflow_OUT    <= 1'b0;
                issue_entry_OUT <= '0;
                issue_valid_OUT <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    slots_q[i] <= nxt[i];
                count_q         <= count_nxt;
                overflow_OUT    <= overflow_OUT | (wr_try & ~wr_acc);
                issue_entry_OUT <= issue ? iss_entry : '0;
                issue_valid_OUT <= issue;
            end
        end
    end

    assign full_ISSQUEUE  = (count_q == CW'(DEPTH));
    assign empty_ISSQUEUE = (count_q == '0);
    assign count_OUT      = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Randomised and directed bench for issue_queue with an in-bench queue model.
module tb_issue_queue;
    localparam int W     = 192;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          freeze, do_write, mis, flc, wk_v, exec_rdy;
    logic [5:0]    wk_r;
    logic [W-1:0]  entry_in;
    logic [W-1:0]  issue_entry_OUT;
    logic          issue_valid_OUT, full_ISSQUEUE, empty_ISSQUEUE, overflow_OUT;
    logic [3:0]    count_OUT;

    issue_queue #(.DEPTH(DEPTH), .ISSUE_ENTRY_SIZE(W)) dut (
        .CLK(CLK), .RESET(rst_n), .FREEZE(freeze), .entry_IN(entry_in),
        .do_write_ISSQUEUE(do_write), .mispredict(mis), .flush_fCOM(flc),
        .wakeup_valid_IN(wk_v), .wakeup_phyReg_IN(wk_r), .exec_ready_IN(exec_rdy),
        .issue_entry_OUT(issue_entry_OUT), .issue_valid_OUT(issue_valid_OUT),
        .full_ISSQUEUE(full_ISSQUEUE), .empty_ISSQUEUE(empty_ISSQUEUE),
        .overflow_OUT(overflow_OUT), .count_OUT(count_OUT)
    );

    always #5 CLK = ~CLK;

    // Reference model: age-ordered queue of entries plus a ready bit per phyReg.
    logic [W-1:0] mq [$];
    bit   [63:0]  msb;
    bit           movf;
    bit           exp_iv;
    logic [W-1:0] exp_ie;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [5:0] sa, input logic ra, input logic [5:0] sb,
                                        input logic rb, input logic [5:0] d, input logic [159:0] pl);
        logic [W-1:0] e;
        e          = '0;
        e[191]     = 1'b1;
        e[179:174] = d;
        e[173:168] = sb;
        e[167]     = rb;
        e[166:161] = sa;
        e[160]     = ra;
        e[159:0]   = pl;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        msb    = 64'h1;
        movf   = 0;
        exp_iv = 0;
        exp_ie = '0;
    endtask

    task automatic model_step();
        bit           fl, iss, wtry, wacc;
        int           k;
        logic [W-1:0] e, ne;
        fl = mis | flc;
        k  = -1;
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
`ifdef ISSQ_WAKEUP_BYPASS_EN
            if (wk_v && e[166:161] == wk_r) e[160] = 1'b1;
            if (wk_v && e[173:168] == wk_r) e[167] = 1'b1;
`endif
            if (k < 0 && e[160] && e[167]) k = i;
        end
        iss  = (k >= 0) && exec_rdy && !freeze && !fl;
        wtry = do_write && !freeze && !fl;
        wacc = wtry && (mq.size() < DEPTH || iss);
        ne = entry_in;
        if (msb[ne[166:161]] || (wk_v && wk_r == ne[166:161])) ne[160] = 1'b1;
        if (msb[ne[173:168]] || (wk_v && wk_r == ne[173:168])) ne[167] = 1'b1;
        if (wk_v) begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (e[166:161] == wk_r) e[160] = 1'b1;
                if (e[173:168] == wk_r) e[167] = 1'b1;
                mq[i] = e;
            end
            msb[wk_r] = 1'b1;
        end
        if (wacc) msb[ne[179:174]] = 1'b0;
        msb[0] = 1'b1;
        if (fl) begin
            mq.delete();
            exp_iv = 0;
            exp_ie = '0;
            movf   = 0;
        end else begin
            if (iss) begin
                e      = mq[k];
                e[180] = 1'b1;
                exp_ie = e;
                exp_iv = 1;
                mq.delete(k);
            end else begin
                exp_iv = 0;
                exp_ie = '0;
            end
            if (wacc) mq.push_back(ne);
            if (wtry && !wacc) movf = 1;
        end
    endtask

    task automatic compare_all();
        chk("count", W'(count_OUT), W'(mq.size()));
        chk("full", W'(full_ISSQUEUE), W'(mq.size() == DEPTH));
        chk("empty", W'(empty_ISSQUEUE), W'(mq.size() == 0));
        chk("overflow", W'(overflow_OUT), W'(movf));
        chk("issue_valid", W'(issue_valid_OUT), W'(exp_iv));
        chk("issue_entry", issue_entry_OUT, exp_ie);
    endtask

    task automatic idle();
        freeze = 0; do_write = 0; mis = 0; flc = 0; wk_v = 0; wk_r = '0; exec_rdy = 0;
        entry_in = '0;
    endtask

    // Inputs are set away from the edge; the model advances with them, then
    // outputs are compared 1 ns after the rising edge.
    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        model_reset();
        #3;
        @(negedge CLK);
        compare_all();
        chk("reset_empty", W'(empty_ISSQUEUE), W'(1));
        rst_n = 1;
        step();
    endtask

    task automatic wr(input logic [W-1:0] e, input logic ex);
        idle();
        entry_in = e; do_write = 1; exec_rdy = ex;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        idle();
        do_reset();

        // Wakeup two cycles after write releases a waiting entry.
        wr(mk(6'd5, 0, 6'd0, 0, 6'd7, 160'hCAFE_0028), 0);
        idle(); step();
        idle(); wk_v = 1; wk_r = 6'd5; exec_rdy = 1; step();
`ifdef ISSQ_WAKEUP_BYPASS_EN
        chk("r28_iv_early", W'(issue_valid_OUT), W'(1));
        chk("r28_payload", W'(issue_entry_OUT[159:0]), W'(160'hCAFE_0028));
        chk("r28_ready", W'(issue_entry_OUT[180]), W'(1));
        idle(); exec_rdy = 1; step();
        chk("r28_one_cycle", W'(issue_valid_OUT), W'(0));
`else
        chk("r28_iv_early", W'(issue_valid_OUT), W'(0));
        idle(); exec_rdy = 1; step();
        chk("r28_iv", W'(issue_valid_OUT), W'(1));
        chk("r28_payload", W'(issue_entry_OUT[159:0]), W'(160'hCAFE_0028));
        chk("r28_ready", W'(issue_entry_OUT[180]), W'(1));
        idle(); exec_rdy = 1; step();
        chk("r28_one_cycle", W'(issue_valid_OUT), W'(0));
`endif

        // Fill, overflow, then write accepted alongside an issue.
        do_reset();
        for (int i = 0; i < DEPTH; i++) wr(mk(6'd20, 0, 6'd21, 0, 6'd30, 160'(i)), 0);
        chk("r29_count8", W'(count_OUT), W'(8));
        chk("r29_full", W'(full_ISSQUEUE), W'(1));
        wr(mk(6'd20, 0, 6'd21, 0, 6'd30, 160'h99), 0);
        chk("r29_overflow", W'(overflow_OUT), W'(1));
        chk("r29_count_hold", W'(count_OUT), W'(8));
        idle(); wk_v = 1; wk_r = 6'd20; step();
        idle(); wk_v = 1; wk_r = 6'd21; step();
        wr(mk(6'd20, 0, 6'd21, 0, 6'd30, 160'h9A), 1);
        chk("r29_iss_iv", W'(issue_valid_OUT), W'(1));
        chk("r29_iss_payload", W'(issue_entry_OUT[159:0]), W'(0));
        chk("r29_iss_count", W'(count_OUT), W'(8));
        chk("r29_ovf_sticky", W'(overflow_OUT), W'(1));

        // Oldest ready first, age order preserved across compaction.
        do_reset();
        wr(mk(6'd40, 0, 6'd0, 0, 6'd50, 160'hA0), 0);
        wr(mk(6'd0, 1, 6'd0, 1, 6'd51, 160'hA1), 0);
        wr(mk(6'd0, 0, 6'd0, 0, 6'd52, 160'hA2), 0);
        idle(); exec_rdy = 1; step();
        chk("r30_first", W'(issue_entry_OUT[159:0]), W'(160'hA1));
        idle(); exec_rdy = 1; step();
        chk("r30_second", W'(issue_entry_OUT[159:0]), W'(160'hA2));
        chk("r30_count", W'(count_OUT), W'(1));

        // Mispredict beats a simultaneous write.
        do_reset();
        for (int i = 0; i < 4; i++) wr(mk(6'd44, 0, 6'd45, 0, 6'd46, 160'(i)), 0);
        idle(); mis = 1; do_write = 1; exec_rdy = 1; entry_in = mk(6'd0, 1, 6'd0, 1, 6'd3, 160'h31);
        step();
        chk("r31_count", W'(count_OUT), W'(0));
        chk("r31_empty", W'(empty_ISSQUEUE), W'(1));
        chk("r31_no_issue", W'(issue_valid_OUT), W'(0));

        // Wakeup during FREEZE is remembered.
        do_reset();
        wr(mk(6'd9, 0, 6'd0, 0, 6'd12, 160'h32), 0);
        idle(); freeze = 1; wk_v = 1; wk_r = 6'd9; exec_rdy = 1; step();
        chk("r32_frozen_iv", W'(issue_valid_OUT), W'(0));
        chk("r32_frozen_cnt", W'(count_OUT), W'(1));
        idle(); exec_rdy = 1; step();
        chk("r32_release_iv", W'(issue_valid_OUT), W'(1));
        chk("r32_release_pl", W'(issue_entry_OUT[159:0]), W'(160'h32));
        // Same-cycle wakeup and selection.
        wr(mk(6'd11, 0, 6'd0, 0, 6'd13, 160'h33), 0);
        idle(); wk_v = 1; wk_r = 6'd11; exec_rdy = 1; step();
`ifdef ISSQ_WAKEUP_BYPASS_EN
        chk("r32_bypass_iv", W'(issue_valid_OUT), W'(1));
`else
        chk("r32_bypass_iv", W'(issue_valid_OUT), W'(0));
        idle(); exec_rdy = 1; step();
        chk("r32_late_iv", W'(issue_valid_OUT), W'(1));
`endif

        // Asynchronous reset while an issue is on the output.
        do_reset();
        for (int i = 0; i < 3; i++) wr(mk(6'd0, 1, 6'd0, 1, 6'd14, 160'(i)), 0);
        idle(); exec_rdy = 1; step();
        chk("r33_pre_iv", W'(issue_valid_OUT), W'(1));
        #2;
        rst_n = 0;
        #1;
        chk("r33_iv", W'(issue_valid_OUT), W'(0));
        chk("r33_empty", W'(empty_ISSQUEUE), W'(1));
        chk("r33_entry", issue_entry_OUT, '0);
        do_reset();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] e;
            idle();
            e = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            e[166:161] = 6'($urandom_range(0, 15));
            e[173:168] = 6'($urandom_range(0, 15));
            e[179:174] = 6'($urandom_range(1, 15));
            e[160]     = ($urandom_range(0, 3) == 0);
            e[167]     = ($urandom_range(0, 3) == 0);
            entry_in   = e;
            do_write   = ($urandom_range(0, 9) < 6);
            freeze     = ($urandom_range(0, 9) == 0);
            mis        = ($urandom_range(0, 59) == 0);
            flc        = ($urandom_range(0, 59) == 0);
            wk_v       = ($urandom_range(0, 9) < 4);
            wk_r       = 6'($urandom_range(0, 15));
            exec_rdy   = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entry slots (power of two, 2..16).
REQ-002 SHALL have parameter ISSUE_ENTRY_SIZE, default 192, entry width in bits.
REQ-003 SHALL have port CLK, input, 1, clock; all state changes on rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port FREEZE, input, 1, pipeline stall.
REQ-006 SHALL have port entry_IN, input, ISSUE_ENTRY_SIZE, entry from issue stage: [191] valid, [180] ready, [179:174] dest phyReg, [173:168] src B phyReg, [167] readyB, [166:161] src A phyReg, [160] readyA, [159:0] payload.
REQ-007 SHALL have port do_write_ISSQUEUE, input, 1, write strobe for entry_IN.
REQ-008 SHALL have ports mispredict and flush_fCOM, input, 1 each, flush requests.
REQ-009 SHALL have ports wakeup_valid_IN, input, 1, and wakeup_phyReg_IN, input, 6, result broadcast.
REQ-010 SHALL have port exec_ready_IN, input, 1, execute stage accepts an entry this cycle.
REQ-011 SHALL have ports issue_entry_OUT, output, ISSUE_ENTRY_SIZE, and issue_valid_OUT, output, 1, registered issued entry.
REQ-012 SHALL have ports full_ISSQUEUE, empty_ISSQUEUE, overflow_OUT, output, 1 each, and count_OUT, output, $clog2(DEPTH)+1.

Function
REQ-013 SHALL store entries in a compacting array; slot 0 is oldest; on removal, younger entries shift down one slot in the same edge.
REQ-014 SHALL keep a 64-bit phyReg ready scoreboard: set bit on wakeup, clear bit of dest phyReg on accepted write; phyReg 0 always ready.
REQ-015 SHALL on accepted write set stored readyA/readyB = incoming bit OR scoreboard bit OR same-cycle wakeup match.
REQ-016 SHALL on each wakeup set readyA/readyB of every valid stored entry whose source phyReg matches, including during FREEZE.
REQ-017 SHALL select, when exec_ready_IN=1 and FREEZE=0, the lowest-index entry with readyA=readyB=1; at most one issue per cycle.
REQ-018 SHALL at the edge, load the selected entry into issue_entry_OUT with bit [180] forced 1, assert issue_valid_OUT for one cycle, remove the entry; else issue_entry_OUT=0, issue_valid_OUT=0.
REQ-019 SHALL accept a write when do_write_ISSQUEUE=1, FREEZE=0 and (count<DEPTH or an issue occurs that edge); new entry placed at tail after compaction.
REQ-020 SHALL ignore a write when full with no simultaneous issue, set overflow_OUT sticky until reset or flush.
REQ-021 SHALL while FREEZE=1 perform no write and no issue; issue_valid_OUT deasserts; entries and count hold.
REQ-022 SHALL on mispredict or flush_fCOM at an edge invalidate all entries, clear count, issue_valid_OUT, issue_entry_OUT, overflow_OUT; flush has priority over write and issue; scoreboard unaffected.
REQ-023 SHALL drive full_ISSQUEUE=(count==DEPTH), empty_ISSQUEUE=(count==0), count_OUT=count, all from registered state.
REQ-024 SHALL latency: entry written at edge E is selectable in the cycle after E and earliest on issue_entry_OUT after edge E+1.

Reset
REQ-025 SHALL on RESET=0 asynchronously clear all entries, count, scoreboard (except phyReg 0), overflow_OUT, issue_entry_OUT=0, issue_valid_OUT=0; empty_ISSQUEUE=1.
REQ-026 SHALL resume normal operation on the first rising edge after RESET deasserts.

Configuration
REQ-027 SHALL provide macro ISSQ_WAKEUP_BYPASS_EN: defined, a wakeup match in cycle C counts as ready for selection in cycle C; undefined, the woken entry is selectable no earlier than cycle C+1.

Verification
REQ-028 SHALL test: write entry srcA=5 srcB=0 not ready, wakeup phyReg 5 two cycles later, exec_ready_IN=1 -> issue_valid_OUT one cycle, issue_entry_OUT[180]=1, payload unchanged.
REQ-029 SHALL test: fill 8 entries, write 9th with no issue -> full_ISSQUEUE=1, overflow_OUT=1, count_OUT=8; 9th write with simultaneous issue -> accepted, count_OUT stays 8.
REQ-030 SHALL test: entries at slots 0 (not ready) and 1,2 (ready) -> slot 1 issues first, then slot 2 (compaction keeps age order).
REQ-031 SHALL test: mispredict with 4 entries and simultaneous write -> next cycle count_OUT=0, empty_ISSQUEUE=1, no issue.
REQ-032 SHALL test: wakeup phyReg 9 during FREEZE, release FREEZE -> entry waiting on 9 issues; with ISSQ_WAKEUP_BYPASS_EN, wakeup and selection same cycle -> issue one cycle earlier than without.
REQ-033 SHALL test: RESET asserted mid-issue -> issue_valid_OUT=0 immediately, empty_ISSQUEUE=1.
